// File: rtl/mult_matrix_sequencer_if.sv
// Handshake and row-strobe bundle between a job source/datapath and mult_matrix_sequencer.
// master = job source (drives start/abort), slave = the sequencer.
interface mult_matrix_sequencer_if #(
    parameter int size = 3
);
    localparam int IDX_W = $clog2(size) + 1;

    logic             start;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             feed_en;
    logic [IDX_W-1:0] feed_idx;
    logic             flush_en;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             done;

    modport master (
        output start, abort,
        input  ready, busy, feed_en, feed_idx, flush_en, out_valid, out_idx, done
    );

    modport slave (
        input  start, abort,
        output ready, busy, feed_en, feed_idx, flush_en, out_valid, out_idx, done
    );
endinterface

// File: rtl/mult_matrix_sequencer.sv
// Job sequencer for the systolic multiplier: feeds rows, flushes, flags de-skewed output rows.
// Optional job/abort counters are enabled with `define MULT_MATRIX_SEQ_PERF_EN.
//
// state   | meaning
// S_IDLE  | waiting for start, ready=1
// S_FEED  | job cycles 0..size-1, real rows into the array
// S_DRAIN | job cycles size..size-1+LAT, zero rows flush the pipeline
module mult_matrix_sequencer #(
    parameter int data_size = 4,
    parameter int size      = 3,
    parameter int array_lat = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_matrix_sequencer_if.slave bus
`ifdef MULT_MATRIX_SEQ_PERF_EN
    ,
    output logic [15:0]           perf_jobs,
    output logic [15:0]           perf_aborts
`endif
);
    localparam int LAT   = array_lat + size;
    localparam int CYC_W = $clog2(size + LAT + 1);
    localparam int IDX_W = $clog2(size) + 1;

    localparam logic [CYC_W-1:0] FEED_LAST = CYC_W'(size - 1);
    localparam logic [CYC_W-1:0] JOB_LAST  = CYC_W'(LAT + size - 1);
    localparam logic [CYC_W-1:0] OUT_FIRST = CYC_W'(LAT);

    if (data_size < 1 || size < 1 || array_lat < 0) begin : g_bad_param
        $error("mult_matrix_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    // abort wins over the FEED->DRAIN and DRAIN->IDLE transitions
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                cyc_d = '0;
                if (bus.start) state_d = S_FEED;
            end
            S_FEED: begin
                cyc_d = cyc_q + 1'b1;
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end else if (cyc_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                if (bus.abort || cyc_q == JOB_LAST) begin
                    state_d = S_IDLE;
                    cyc_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == S_FEED) || (state_q == S_DRAIN);

    // cyc-LAT always lies in 0..size-1 while out_valid, so the narrow subtraction is exact
    always_comb begin
        bus.ready     = (state_q == S_IDLE);
        bus.busy      = busy;
        bus.feed_en   = (state_q == S_FEED);
        bus.feed_idx  = '0;
        bus.flush_en  = (state_q == S_DRAIN);
        bus.out_valid = busy && (cyc_q >= OUT_FIRST);
        bus.out_idx   = '0;
        bus.done      = busy && (cyc_q == JOB_LAST);
        if (state_q == S_FEED) bus.feed_idx = cyc_q[IDX_W-1:0];
        if (bus.out_valid)     bus.out_idx  = cyc_q[IDX_W-1:0] - IDX_W'(LAT);
    end

`ifdef MULT_MATRIX_SEQ_PERF_EN
    logic [15:0] perf_jobs_q, perf_aborts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_jobs_q   <= '0;
            perf_aborts_q <= '0;
        end else begin
            if (bus.done && perf_jobs_q != 16'hFFFF)
                perf_jobs_q <= perf_jobs_q + 16'd1;
            if (busy && bus.abort && perf_aborts_q != 16'hFFFF)
                perf_aborts_q <= perf_aborts_q + 16'd1;
        end
    end

    assign perf_jobs   = perf_jobs_q;
    assign perf_aborts = perf_aborts_q;
`endif
endmodule

// File: tb/tb_mult_matrix_sequencer.sv
// Directed bench for mult_matrix_sequencer: default geometry plus a size=4, array_lat=0 instance.
module tb_mult_matrix_sequencer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    mult_matrix_sequencer_if #(.size(3)) ifa ();
    mult_matrix_sequencer_if #(.size(4)) ifb ();

`ifdef MULT_MATRIX_SEQ_PERF_EN
    logic [15:0] pj_a, pa_a, pj_b, pa_b;
`endif

    mult_matrix_sequencer #(.data_size(4), .size(3), .array_lat(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
`ifdef MULT_MATRIX_SEQ_PERF_EN
        ,
        .perf_jobs   (pj_a),
        .perf_aborts (pa_a)
`endif
    );

    mult_matrix_sequencer #(.data_size(4), .size(4), .array_lat(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
`ifdef MULT_MATRIX_SEQ_PERF_EN
        ,
        .perf_jobs   (pj_b),
        .perf_aborts (pa_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ready, busy, feed_en, feed_idx[2:0], flush_en, out_valid, out_idx[2:0], done}
    function automatic logic [11:0] ev(input logic rdy, input logic bsy, input logic fe,
                                       input logic [2:0] fi, input logic fl, input logic ov,
                                       input logic [2:0] oi, input logic dn);
        return {rdy, bsy, fe, fi, fl, ov, oi, dn};
    endfunction

    function automatic logic [11:0] v_idle();
        return ev(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    endfunction
    function automatic logic [11:0] v_feed(input logic [2:0] i);
        return ev(1'b0, 1'b1, 1'b1, i, 1'b0, 1'b0, 3'd0, 1'b0);
    endfunction
    function automatic logic [11:0] v_flush();
        return ev(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0);
    endfunction
    function automatic logic [11:0] v_fout(input logic [2:0] i, input logic d);
        return ev(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, i, d);
    endfunction

    function automatic logic [11:0] act_a();
        return {ifa.ready, ifa.busy, ifa.feed_en, ifa.feed_idx, ifa.flush_en,
                ifa.out_valid, ifa.out_idx, ifa.done};
    endfunction
    function automatic logic [11:0] act_b();
        return {ifb.ready, ifb.busy, ifb.feed_en, ifb.feed_idx, ifb.flush_en,
                ifb.out_valid, ifb.out_idx, ifb.done};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        start;
        logic        abort;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [0:24];

    task automatic put(input int i, input logic s, input logic a, input logic [11:0] e);
        tbl[i] = '{start: s, abort: a, exp: e};
    endtask

    // Each record: outputs expected at this negedge, inputs applied for the next rising edge.
    task automatic run_tbl(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), {4'd0, act_a()}, {4'd0, tbl[i].exp});
            ifa.start = tbl[i].start;
            ifa.abort = tbl[i].abort;
        end
    endtask

    task automatic wait_done_a(input string nm);
        int n;
        n = 0;
        while (ifa.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {15'd0, (n < 40)}, 16'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        ifb.start = 1'b0;
        ifb.abort = 1'b0;

        put( 0, 1, 0, v_idle());
        put( 1, 0, 0, v_feed(3'd0));
        put( 2, 0, 0, v_feed(3'd1));
        put( 3, 0, 0, v_feed(3'd2));
        put( 4, 0, 0, v_flush());
        put( 5, 0, 0, v_flush());
        put( 6, 0, 0, v_fout(3'd0, 1'b0));
        put( 7, 0, 0, v_fout(3'd1, 1'b0));
        put( 8, 0, 0, v_fout(3'd2, 1'b1));
        put( 9, 0, 0, v_idle());
        put(10, 1, 0, v_idle());
        put(11, 0, 0, v_feed(3'd0));
        put(12, 0, 1, v_feed(3'd1));
        put(13, 0, 1, v_idle());
        put(14, 1, 0, v_idle());
        put(15, 0, 0, v_feed(3'd0));
        put(16, 0, 0, v_feed(3'd1));
        put(17, 1, 0, v_feed(3'd2));
        put(18, 0, 0, v_flush());
        put(19, 0, 0, v_flush());
        put(20, 0, 0, v_fout(3'd0, 1'b0));
        put(21, 0, 0, v_fout(3'd1, 1'b0));
        put(22, 0, 0, v_fout(3'd2, 1'b1));
        put(23, 0, 0, v_idle());
        put(24, 0, 0, v_idle());

        #1;
        chk("reset_a", {4'd0, act_a()}, {4'd0, v_idle()});
        chk("reset_b", {4'd0, act_b()}, {4'd0, v_idle()});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // basic job, abort in FEED, restart, start-while-busy ignored
        run_tbl(0, 24, "tbl");
`ifdef MULT_MATRIX_SEQ_PERF_EN
        chk("perf_jobs_tbl", pj_a, 16'd2);
        chk("perf_aborts_tbl", pa_a, 16'd1);
`endif

        // start held high: exactly one IDLE cycle between done and next cycle 0
        ifa.start = 1'b1;
        for (int j = 0; j < 2; j++) begin
            wait_done_a($sformatf("b2b_done%0d", j));
            @(negedge clk);
            chk($sformatf("b2b_gap%0d", j), {4'd0, act_a()}, {4'd0, v_idle()});
            @(negedge clk);
            chk($sformatf("b2b_c0_%0d", j), {4'd0, act_a()}, {4'd0, v_feed(3'd0)});
        end
        ifa.start = 1'b0;
        wait_done_a("b2b_done2");
        @(negedge clk);
        chk("b2b_end0", {4'd0, act_a()}, {4'd0, v_idle()});
        @(negedge clk);
        chk("b2b_end1", {4'd0, act_a()}, {4'd0, v_idle()});
`ifdef MULT_MATRIX_SEQ_PERF_EN
        chk("perf_jobs_b2b", pj_a, 16'd5);
`endif

        // asynchronous reset in job cycle 4 (DRAIN)
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        chk("rst_c0", {4'd0, act_a()}, {4'd0, v_feed(3'd0)});
        repeat (4) @(negedge clk);
        chk("rst_c4", {4'd0, act_a()}, {4'd0, v_flush()});
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {4'd0, act_a()}, {4'd0, v_idle()});
`ifdef MULT_MATRIX_SEQ_PERF_EN
        chk("perf_jobs_rst", pj_a, 16'd0);
        chk("perf_aborts_rst", pa_a, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release", {4'd0, act_a()}, {4'd0, v_idle()});
        run_tbl(0, 9, "post_rst0");
        run_tbl(0, 9, "post_rst1");
        run_tbl(0, 9, "post_rst2");
`ifdef MULT_MATRIX_SEQ_PERF_EN
        chk("perf_jobs_3", pj_a, 16'd3);
        chk("perf_aborts_3", pa_a, 16'd0);
        #2 reset = 1'b1;
        #1;
        chk("perf_jobs_clr", pj_a, 16'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        // size=4, array_lat=0: LAT=4, out_valid overlaps nothing but starts right after FEED
        @(negedge clk);
        ifb.start = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            logic [11:0] e;
            @(negedge clk);
            ifb.start = 1'b0;
            if (c < 4)
                e = v_feed(3'(c));
            else if (c <= 7)
                e = v_fout(3'(c - 4), (c == 7));
            else
                e = v_idle();
            chk($sformatf("lat0_c%0d", c), {4'd0, act_b()}, {4'd0, e});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
